// File: rtl/write_frame_func.sv
// write_frame_func: emits one Ethernet frame, a header followed by payload beats read from a word memory.
// Latency: header valid 1 cycle after start; first payload beat 1 cycle after the first memory read.
// Backpressure: header holds until s_eth_hdr_ready; a 2-entry buffer absorbs tready stalls and reads are credit-throttled.
module write_frame_func #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int ADDR_WIDTH = 16,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  payload_len,
  input  logic [47:0]           dest_mac_in,
  input  logic [47:0]           src_mac_in,
  input  logic [15:0]           eth_type_in,
  output logic                  idle,
  output logic                  valid,
  output logic                  pay_ren,
  output logic [ADDR_WIDTH-1:0] pay_raddr,
  input  logic [DATA_WIDTH-1:0] pay_rdata,
  output logic                  s_eth_hdr_valid,
  input  logic                  s_eth_hdr_ready,
  output logic [47:0]           s_eth_dest_mac,
  output logic [47:0]           s_eth_src_mac,
  output logic [15:0]           s_eth_type,
  output logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
  output logic                  s_eth_payload_axis_tvalid,
  input  logic                  s_eth_payload_axis_tready,
  output logic                  s_eth_payload_axis_tlast,
  output logic                  s_eth_payload_axis_tuser,
  input  logic                  busy
);

  localparam int KEEP_SHIFT = $clog2(KEEP_WIDTH);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DONE} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic                  rd_done;

  // Beat whose memory read was issued last cycle; its data is on pay_rdata now.
  logic                  fl_vld;
  logic                  fl_last;
  logic [KEEP_WIDTH-1:0] fl_keep;

  // Two-entry skid buffer for beats that could not leave when they arrived.
  logic [DATA_WIDTH-1:0] buf_data [2];
  logic [KEEP_WIDTH-1:0] buf_keep [2];
  logic                  buf_last [2];
  logic                  buf_wr;
  logic                  buf_rd;
  logic [1:0]            buf_cnt;

  logic [LEN_WIDTH-1:0]  rem;
  logic [KEEP_WIDTH-1:0] last_keep;
  logic [1:0]            owned;
  logic                  rd_last;
  logic                  ren;
  logic                  hs;
  logic                  push;
  logic                  pop;

  assign rem     = len_q & LEN_WIDTH'(KEEP_WIDTH - 1);
  assign rd_last = (rd_idx == last_idx);
  assign owned   = buf_cnt + {1'b0, fl_vld};
  assign hs      = s_eth_payload_axis_tvalid & s_eth_payload_axis_tready;

  // A read is only issued if every beat already owned plus the new one fits in the buffer,
  // counting a beat leaving this cycle as freed space.
  assign ren       = !rst && (state == PAYLOAD) && !rd_done && ((owned < 2'd2) || hs);
  assign pay_ren   = ren;
  assign pay_raddr = ren ? rd_idx : '0;

  // An arriving beat bypasses the buffer when the buffer is empty and the sink takes it now.
  assign push = fl_vld && !((buf_cnt == 2'd0) && s_eth_payload_axis_tready);
  assign pop  = hs && (buf_cnt != 2'd0);

  assign s_eth_payload_axis_tvalid = (buf_cnt != 2'd0) || fl_vld;
  assign s_eth_payload_axis_tuser  = 1'b0;

  // Byte enables of the final beat: low (len mod KEEP_WIDTH) bytes, or all when the remainder is zero.
  always_comb begin
    last_keep = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      last_keep[i] = (rem == '0) || (LEN_WIDTH'(i) < rem);
    end
  end

  // Present the oldest buffered beat, else the beat arriving from memory this cycle.
  always_comb begin
    s_eth_payload_axis_tdata = '0;
    s_eth_payload_axis_tkeep = '0;
    s_eth_payload_axis_tlast = 1'b0;
    if (buf_cnt != 2'd0) begin
      s_eth_payload_axis_tdata = buf_data[buf_rd];
      s_eth_payload_axis_tkeep = buf_keep[buf_rd];
      s_eth_payload_axis_tlast = buf_last[buf_rd];
    end else if (fl_vld) begin
      s_eth_payload_axis_tdata = pay_rdata;
      s_eth_payload_axis_tkeep = fl_keep;
      s_eth_payload_axis_tlast = fl_last;
    end
  end

  // Track in-flight read and maintain the skid buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      fl_vld  <= 1'b0;
      fl_last <= 1'b0;
      fl_keep <= '0;
      buf_wr  <= 1'b0;
      buf_rd  <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      fl_vld  <= ren;
      fl_last <= ren && rd_last;
      fl_keep <= (ren && rd_last) ? last_keep : '1;
      if (push) begin
        buf_data[buf_wr] <= pay_rdata;
        buf_keep[buf_wr] <= fl_keep;
        buf_last[buf_wr] <= fl_last;
        buf_wr           <= ~buf_wr;
      end
      if (pop) begin
        buf_rd <= ~buf_rd;
      end
      buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // Frame sequencing: accept request, offer header, walk payload addresses, pulse completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      idle            <= 1'b1;
      valid           <= 1'b0;
      s_eth_hdr_valid <= 1'b0;
      s_eth_dest_mac  <= '0;
      s_eth_src_mac   <= '0;
      s_eth_type      <= '0;
      len_q           <= '0;
      rd_idx          <= '0;
      last_idx        <= '0;
      rd_done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start && !busy) begin
            s_eth_dest_mac  <= dest_mac_in;
            s_eth_src_mac   <= src_mac_in;
            s_eth_type      <= eth_type_in;
            len_q           <= payload_len;
            s_eth_hdr_valid <= 1'b1;
            idle            <= 1'b0;
            state           <= HDR;
          end
        end
        HDR: begin
          if (s_eth_hdr_ready) begin
            s_eth_hdr_valid <= 1'b0;
            rd_idx          <= '0;
            rd_done         <= 1'b0;
            // Index of the final beat; computed from len-1 so the maximum length cannot overflow.
            last_idx        <= ADDR_WIDTH'((len_q - LEN_WIDTH'(1)) >> KEEP_SHIFT);
            if (len_q == '0) begin
              valid <= 1'b1;
              state <= DONE;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (ren) begin
            if (rd_last) begin
              rd_done <= 1'b1;
            end else begin
              rd_idx <= rd_idx + ADDR_WIDTH'(1);
            end
          end
          if (hs && s_eth_payload_axis_tlast) begin
            valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          valid <= 1'b0;
          idle  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          idle  <= 1'b1;
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_frame_func.sv
// Bench for write_frame_func: 8-bit and 32-bit instances, directed frames.
// Stimulus pushes expected headers/beats into queues; a negedge monitor pops on handshakes.
// Inputs change 2 time units after the rising edge; outputs sampled on the falling edge or after the edge.
`timescale 1ns/1ps
module tb_write_frame_func;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic busy;

  // 8-bit instance
  logic        a_start;
  logic [15:0] a_len;
  logic [47:0] a_dst, a_src;
  logic [15:0] a_type;
  logic        a_idle, a_valid, a_pay_ren;
  logic [15:0] a_pay_raddr;
  logic [7:0]  a_pay_rdata;
  logic        a_hdr_valid, a_hdr_ready;
  logic [47:0] a_hdr_dst, a_hdr_src;
  logic [15:0] a_hdr_type;
  logic [7:0]  a_tdata;
  logic [0:0]  a_tkeep;
  logic        a_tvalid, a_tready, a_tlast, a_tuser;

  // 32-bit instance
  logic        b_start;
  logic [15:0] b_len;
  logic        b_idle, b_valid, b_pay_ren;
  logic [15:0] b_pay_raddr;
  logic [31:0] b_pay_rdata;
  logic        b_hdr_valid, b_hdr_ready;
  logic [47:0] b_hdr_dst, b_hdr_src;
  logic [15:0] b_hdr_type;
  logic [31:0] b_tdata;
  logic [3:0]  b_tkeep;
  logic        b_tvalid, b_tready, b_tlast, b_tuser;

  write_frame_func #(.DATA_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .payload_len(a_len),
    .dest_mac_in(a_dst), .src_mac_in(a_src), .eth_type_in(a_type),
    .idle(a_idle), .valid(a_valid), .pay_ren(a_pay_ren), .pay_raddr(a_pay_raddr),
    .pay_rdata(a_pay_rdata), .s_eth_hdr_valid(a_hdr_valid), .s_eth_hdr_ready(a_hdr_ready),
    .s_eth_dest_mac(a_hdr_dst), .s_eth_src_mac(a_hdr_src), .s_eth_type(a_hdr_type),
    .s_eth_payload_axis_tdata(a_tdata), .s_eth_payload_axis_tkeep(a_tkeep),
    .s_eth_payload_axis_tvalid(a_tvalid), .s_eth_payload_axis_tready(a_tready),
    .s_eth_payload_axis_tlast(a_tlast), .s_eth_payload_axis_tuser(a_tuser), .busy(busy)
  );

  write_frame_func #(.DATA_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .payload_len(b_len),
    .dest_mac_in(48'h0A0B0C0D0E0F), .src_mac_in(48'h102030405060), .eth_type_in(16'h86DD),
    .idle(b_idle), .valid(b_valid), .pay_ren(b_pay_ren), .pay_raddr(b_pay_raddr),
    .pay_rdata(b_pay_rdata), .s_eth_hdr_valid(b_hdr_valid), .s_eth_hdr_ready(b_hdr_ready),
    .s_eth_dest_mac(b_hdr_dst), .s_eth_src_mac(b_hdr_src), .s_eth_type(b_hdr_type),
    .s_eth_payload_axis_tdata(b_tdata), .s_eth_payload_axis_tkeep(b_tkeep),
    .s_eth_payload_axis_tvalid(b_tvalid), .s_eth_payload_axis_tready(b_tready),
    .s_eth_payload_axis_tlast(b_tlast), .s_eth_payload_axis_tuser(b_tuser), .busy(busy)
  );

  // Synchronous-read payload memories
  logic [7:0] mem_a [256];
  always @(posedge clk) if (a_pay_ren) a_pay_rdata <= mem_a[a_pay_raddr[7:0]];
  always @(posedge clk) if (b_pay_ren) b_pay_rdata <= {b_pay_raddr ^ 16'hA5A5, b_pay_raddr};

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;
  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] typ;
  } hdr_t;

  beat_t qa[$];
  beat_t qb[$];
  hdr_t  qh[$];

  int checks = 0;
  int errors = 0;
  int a_tlast_cnt = 0;
  logic tmode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // tready driver: constant 1, or the repeating 1,0,0 pattern
  initial begin
    int k;
    k = 0;
    a_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (tmode) begin
        a_tready = ((k % 3) == 0);
        k++;
      end else begin
        a_tready = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  hdr_t        mh;
  beat_t       mb;
  logic        a_stall_prev = 1'b0;
  logic [7:0]  a_data_prev;
  logic        a_last_prev;
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      a_stall_prev = 1'b0;
    end else begin
      if (a_hdr_valid && a_hdr_ready) begin
        if (qh.size() == 0) begin
          checks++; errors++;
          $display("FAIL hdr_unexpected: got header type %0h expected none", a_hdr_type);
        end else begin
          mh = qh.pop_front();
          check("hdr_dst", a_hdr_dst, mh.dst);
          check("hdr_src", a_hdr_src, mh.src);
          check("hdr_type", a_hdr_type, mh.typ);
        end
      end
      if (a_stall_prev) begin
        check("stall_tvalid", a_tvalid, 1'b1);
        check("stall_tdata", a_tdata, a_data_prev);
        check("stall_tlast", a_tlast, a_last_prev);
      end
      if (a_tvalid && a_tready) begin
        if (a_tlast) a_tlast_cnt++;
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_beat_unexpected: got data %0h expected none", a_tdata);
        end else begin
          mb = qa.pop_front();
          check("a_tdata", a_tdata, mb.data);
          check("a_tkeep", a_tkeep, mb.keep);
          check("a_tlast", a_tlast, mb.last);
        end
      end
      a_stall_prev = a_tvalid && !a_tready;
      a_data_prev  = a_tdata;
      a_last_prev  = a_tlast;
      if (b_tvalid && b_tready) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_beat_unexpected: got data %0h expected none", b_tdata);
        end else begin
          mb = qb.pop_front();
          check("b_tdata", b_tdata, mb.data);
          check("b_tkeep", b_tkeep, mb.keep);
          check("b_tlast", b_tlast, mb.last);
        end
      end
    end
  end

  task automatic start_a(input logic [15:0] len, input logic [47:0] dst,
                         input logic [47:0] src, input logic [15:0] typ);
    hdr_t  h;
    beat_t b;
    h.dst = dst; h.src = src; h.typ = typ;
    qh.push_back(h);
    for (int i = 0; i < int'(len); i++) begin
      b.data = {24'h0, mem_a[i]};
      b.keep = 4'h1;
      b.last = (i == int'(len) - 1);
      qa.push_back(b);
    end
    a_len = len; a_dst = dst; a_src = src; a_type = typ;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic wait_valid_a(input int budget, input string name);
    int n;
    n = 0;
    while (a_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, a_valid, 1'b1);
    tick();
  endtask

  task automatic wait_valid_b(input int budget, input string name);
    int n;
    n = 0;
    while (b_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(name, b_valid, 1'b1);
    tick();
  endtask

  // Per-cycle expectations for the 3-byte frame: {hdr_valid, pay_ren, tvalid, tlast, valid, idle}
  logic [5:0]  t1_flags [7];
  logic [7:0]  t1_data  [7];
  logic [15:0] t1_addr  [7];

  initial begin
    beat_t b;
    int    n;
    int    tl0;
    logic  found;

    rst = 1'b1; busy = 1'b0;
    a_start = 1'b0; a_len = '0; a_dst = '0; a_src = '0; a_type = '0; a_hdr_ready = 1'b1;
    b_start = 1'b0; b_len = '0; b_hdr_ready = 1'b1; b_tready = 1'b1;
    for (int i = 0; i < 256; i++) mem_a[i] = 8'h00;

    t1_flags[0] = 6'b100000; t1_data[0] = 8'h00; t1_addr[0] = 16'd0;
    t1_flags[1] = 6'b010000; t1_data[1] = 8'h00; t1_addr[1] = 16'd0;
    t1_flags[2] = 6'b011000; t1_data[2] = 8'hA1; t1_addr[2] = 16'd1;
    t1_flags[3] = 6'b011000; t1_data[3] = 8'hB2; t1_addr[3] = 16'd2;
    t1_flags[4] = 6'b001100; t1_data[4] = 8'hC3; t1_addr[4] = 16'd0;
    t1_flags[5] = 6'b000010; t1_data[5] = 8'h00; t1_addr[5] = 16'd0;
    t1_flags[6] = 6'b000001; t1_data[6] = 8'h00; t1_addr[6] = 16'd0;

    repeat (3) tick();

    // Reset state
    check("rst_idle", a_idle, 1'b1);
    check("rst_valid", a_valid, 1'b0);
    check("rst_hdr_valid", a_hdr_valid, 1'b0);
    check("rst_tvalid", a_tvalid, 1'b0);
    check("rst_pay_ren", a_pay_ren, 1'b0);
    check("rst_tuser", a_tuser, 1'b0);
    check("rst_hdr_dst", a_hdr_dst, 48'h0);
    check("rst_b_idle", b_idle, 1'b1);
    rst = 1'b0;
    tick();

    // Basic 3-byte frame, cycle by cycle
    mem_a[0] = 8'hA1; mem_a[1] = 8'hB2; mem_a[2] = 8'hC3;
    start_a(16'd3, 48'h112233445566, 48'hAABBCCDDEEFF, 16'h0800);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t1_flags_c%0d", i),
            {a_hdr_valid, a_pay_ren, a_tvalid, a_tlast, a_valid, a_idle}, t1_flags[i]);
      if (t1_flags[i][3]) check($sformatf("t1_tdata_c%0d", i), a_tdata, t1_data[i]);
      if (t1_flags[i][4]) check($sformatf("t1_raddr_c%0d", i), a_pay_raddr, t1_addr[i]);
      if (i < 6) tick();
    end
    check("t1_drained", qa.size(), 0);

    // Zero-length frame
    start_a(16'd0, 48'h010203040506, 48'h0708090A0B0C, 16'h88B5);
    check("t2_hdr_valid", a_hdr_valid, 1'b1);
    check("t2_pay_ren_hdr", a_pay_ren, 1'b0);
    tick();
    check("t2_valid", a_valid, 1'b1);
    check("t2_pay_ren", a_pay_ren, 1'b0);
    check("t2_tvalid", a_tvalid, 1'b0);
    tick();
    check("t2_idle", a_idle, 1'b1);
    check("t2_valid_off", a_valid, 1'b0);

    // Header stall for 5 cycles; a start during HDR is ignored
    a_hdr_ready = 1'b0;
    mem_a[0] = 8'h5A; mem_a[1] = 8'h6B;
    start_a(16'd2, 48'hCAFE00000001, 48'hBEEF00000002, 16'h0806);
    a_start = 1'b1; a_dst = 48'hFFFFFFFFFFFF; a_type = 16'hFFFF; a_len = 16'd9;
    for (int i = 0; i < 5; i++) begin
      check("t3_hdr_valid", a_hdr_valid, 1'b1);
      check("t3_dst", a_hdr_dst, 48'hCAFE00000001);
      check("t3_src", a_hdr_src, 48'hBEEF00000002);
      check("t3_type", a_hdr_type, 16'h0806);
      check("t3_pay_ren", a_pay_ren, 1'b0);
      tick();
    end
    a_start = 1'b0;
    a_hdr_ready = 1'b1;
    wait_valid_a(50, "t3_done");
    check("t3_drained", qa.size(), 0);

    // 8-byte frame with tready pattern 1,0,0
    for (int i = 0; i < 8; i++) mem_a[i] = 8'(8'h11 * (i + 1));
    tl0 = a_tlast_cnt;
    tmode = 1'b1;
    start_a(16'd8, 48'h000000000008, 48'h000000000080, 16'h1234);
    wait_valid_a(200, "t4_done");
    tmode = 1'b0;
    check("t4_drained", qa.size(), 0);
    check("t4_single_tlast", a_tlast_cnt - tl0, 1);

    // start while busy is ignored
    busy = 1'b1; a_start = 1'b1;
    repeat (3) begin
      tick();
      check("busy_idle", a_idle, 1'b1);
      check("busy_hdr_valid", a_hdr_valid, 1'b0);
    end
    a_start = 1'b0; busy = 1'b0;
    tick();

    // 32-bit, 6 bytes: keep 1111 then 0011
    b.data = 32'hA5A50000; b.keep = 4'hF; b.last = 1'b0; qb.push_back(b);
    b.data = 32'hA5A40001; b.keep = 4'h3; b.last = 1'b1; qb.push_back(b);
    b_len = 16'd6; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("t5_hdr_valid", b_hdr_valid, 1'b1);
    check("t5_hdr_type", b_hdr_type, 16'h86DD);
    wait_valid_b(50, "t5_done");
    check("t5_drained", qb.size(), 0);

    // Reset during beat 2 of 4, then a new frame right after reset
    mem_a[0] = 8'hC0; mem_a[1] = 8'hC1; mem_a[2] = 8'hC2; mem_a[3] = 8'hC3;
    start_a(16'd4, 48'h00000000000A, 48'h00000000000B, 16'h0001);
    found = 1'b0; n = 0;
    while (!found && n < 20) begin
      if (a_tvalid && a_tdata == 8'hC1) found = 1'b1;
      else begin tick(); n++; end
    end
    check("t6_reached_beat2", found, 1'b1);
    rst = 1'b1;
    tick();
    check("t6_idle", a_idle, 1'b1);
    check("t6_tvalid", a_tvalid, 1'b0);
    check("t6_tlast", a_tlast, 1'b0);
    check("t6_tdata", a_tdata, 8'h00);
    check("t6_tkeep", a_tkeep, 1'b0);
    check("t6_hdr_valid", a_hdr_valid, 1'b0);
    check("t6_valid", a_valid, 1'b0);
    check("t6_pay_ren", a_pay_ren, 1'b0);
    check("t6_hdr_dst", a_hdr_dst, 48'h0);
    qa.delete();
    rst = 1'b0;
    mem_a[0] = 8'hD0; mem_a[1] = 8'hD1; mem_a[2] = 8'hD2;
    start_a(16'd3, 48'h00000000000C, 48'h00000000000D, 16'h0002);
    check("t6_restart_hdr", a_hdr_valid, 1'b1);
    wait_valid_a(50, "t6_done");
    check("t6_drained", qa.size(), 0);
    check("t6_hdr_drained", qh.size(), 0);

    // Maximum length on the 32-bit instance: 16384 beats, final keep 0111
    for (int i = 0; i < 16384; i++) begin
      b.data = {16'(i) ^ 16'hA5A5, 16'(i)};
      b.keep = (i == 16383) ? 4'h7 : 4'hF;
      b.last = (i == 16383);
      qb.push_back(b);
    end
    b_len = 16'hFFFF; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    wait_valid_b(20000, "t7_done");
    check("t7_drained", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_frame_func.md
WRITE_FRAME_FUNC -- requirements
Module: write_frame_func

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload beat width in bits, a multiple of 8; KEEP_WIDTH = DATA_WIDTH/8.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, width of the payload byte count.
REQ-003 SHALL have parameter ADDR_WIDTH, default 16, payload memory word address width; it SHALL be at least LEN_WIDTH - log2(KEEP_WIDTH).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have the ports below (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request to send one frame.
- payload_len  in  LEN_WIDTH  payload bytes, sampled with start.
- dest_mac_in  in  48  destination MAC, sampled with start.
- src_mac_in  in  48  source MAC, sampled with start.
- eth_type_in  in  16  EtherType, sampled with start.
- idle  out  1  high when start can be accepted.
- valid  out  1  one-cycle pulse when the frame is complete.
- pay_ren  out  1  payload memory read enable.
- pay_raddr  out  ADDR_WIDTH  payload word address, beat index from 0.
- pay_rdata  in  DATA_WIDTH  read data, valid the cycle after pay_ren.
- s_eth_hdr_valid  out  1  header valid.
- s_eth_hdr_ready  in  1  header ready.
- s_eth_dest_mac  out  48  registered header field.
- s_eth_src_mac  out  48  registered header field.
- s_eth_type  out  16  registered header field.
- s_eth_payload_axis_tdata  out  DATA_WIDTH  payload beat.
- s_eth_payload_axis_tkeep  out  KEEP_WIDTH  byte enables.
- s_eth_payload_axis_tvalid  out  1  beat valid.
- s_eth_payload_axis_tready  in  1  beat ready.
- s_eth_payload_axis_tlast  out  1  last beat of the frame.
- s_eth_payload_axis_tuser  out  1  tied 0.
- busy  in  1  downstream transmitter busy.

Function
REQ-006 SHALL use states IDLE, HDR, PAYLOAD, DONE.
REQ-007 In IDLE, idle=1; start=1 and busy=0 SHALL latch all sampled inputs and move to HDR next cycle; start while busy=1 or outside IDLE SHALL be ignored.
REQ-008 In HDR, s_eth_hdr_valid SHALL be 1 with the latched fields stable until s_eth_hdr_ready=1 in the same cycle.
REQ-009 On header handshake: if payload_len==0, go to DONE; otherwise go to PAYLOAD.
REQ-010 Beat count SHALL be N = ceil(payload_len/KEEP_WIDTH); beats read addresses 0..N-1 in order, each exactly once.
REQ-011 The first pay_ren SHALL be asserted on the first PAYLOAD cycle, and the first tvalid SHALL be asserted on the cycle after it.
REQ-012 A 2-entry output buffer SHALL sustain one beat per cycle while tready=1.
REQ-013 Reads SHALL be issued only when buffer space is guaranteed, and no beat SHALL be lost or duplicated.
REQ-014 While tvalid=1 and tready=0, tdata, tkeep and tlast SHALL hold stable.
REQ-015 tkeep SHALL be all ones except on the last beat, which SHALL set the low (payload_len mod KEEP_WIDTH) bits; if that remainder is 0, all bits SHALL be set.
REQ-016 tlast SHALL be 1 only on beat N-1.
REQ-017 The tlast handshake SHALL move the FSM to DONE.
REQ-018 DONE SHALL last one cycle with valid=1, then return to IDLE; start is not accepted in DONE.
REQ-019 The beat counter SHALL not wrap: payload_len = 2^LEN_WIDTH-1 SHALL produce exactly N beats.

Reset
REQ-020 When rst=1, next state SHALL be IDLE, from any state including mid-header or mid-payload.
REQ-021 On reset, all outputs SHALL go to 0 except idle=1, and the buffer SHALL be emptied.
REQ-022 No tlast SHALL be emitted for an aborted frame.
REQ-023 A start in the first cycle after rst falls SHALL be accepted.

Verification
REQ-024 DATA_WIDTH=8, len=3, hdr_ready=1, tready=1, mem={A1,B2,C3}: hdr_valid for 1 cycle, then beats A1,B2,C3 on consecutive cycles, tlast on C3, valid pulse on the next cycle.
REQ-025 len=0: header handshake only, tvalid never asserted, no pay_ren, valid 1 cycle after the handshake.
REQ-026 hdr_ready held 0 for 5 cycles: hdr_valid=1 with constant fields for all 5 cycles, pay_ren=0 throughout.
REQ-027 len=8 with tready toggling 1,0,0,1,...: sequence mem[0..7] exact, tdata stable during stalls, single tlast.
REQ-028 DATA_WIDTH=32, len=6: 2 beats, tkeep 1111 then 0011, tlast on beat 2.
REQ-029 rst during beat 2 of 4: all outputs 0 and idle=1 next cycle; a new start is then accepted and a full frame sent.
